// File: rtl/dmem_if.sv
// CPU-side data-memory bus: address, direction and the responder's status.
// The bidirectional data lines stay a plain port on the responder so the
// tristate driver and its release logic live next to each other.
interface dmem_if;
    logic [31:0] dmem_addr;
    logic        dmem_wen;
    logic        err_misaligned;
    logic        err_range;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    // CPU side: issues address and direction, observes status.
    modport master (
        output dmem_addr,
        output dmem_wen,
        input  err_misaligned,
        input  err_range,
        input  rd_count,
        input  wr_count
    );

    // Memory side: consumes address and direction, reports status.
    modport slave (
        input  dmem_addr,
        input  dmem_wen,
        output err_misaligned,
        output err_range,
        output rd_count,
        output wr_count
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory answering a CPU over a shared bidirectional bus.
// Every clock edge is either a write (dmem_wen=1) or a read (dmem_wen=0).
// Read data is registered and appears on dmem_data the cycle after the
// address; the driver releases combinationally as soon as dmem_wen rises or
// reset asserts. Misaligned and out-of-range accesses raise sticky flags,
// never touch memory and read back as zero.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_if.slave       bus,
    inout  wire  [31:0] dmem_data
);
    localparam int AW = $clog2(DEPTH_WORDS);

    // Storage is excluded from reset so contents survive it; it powers up clear.
    logic [31:0]   r_mem [DEPTH_WORDS] = '{default: '0};
    logic          r_drive;
    logic [31:0]   r_rdata;
    logic          r_err_misaligned;
    logic          r_err_range;
    logic [15:0]   r_rd_count;
    logic [15:0]   r_wr_count;

    logic          w_aligned;
    logic          w_in_range;
    logic          w_valid;
    logic [AW-1:0] w_index;

    assign w_aligned  = (bus.dmem_addr[1:0] == 2'b00);
    assign w_in_range = ({2'b00, bus.dmem_addr[31:2]} < 32'(DEPTH_WORDS));
    assign w_valid    = w_aligned && w_in_range;
    assign w_index    = bus.dmem_addr[AW+1:2];

    // Commit valid writes; an unknown dmem_wen fails the test and writes nothing.
    always_ff @(posedge clk) begin
        if (bus.dmem_wen && w_valid) begin
            r_mem[w_index] <= dmem_data;
        end
    end

    // Read pipeline: capture data on read edges, drop the bus on write edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drive <= 1'b0;
            r_rdata <= 32'h0;
        end else if (bus.dmem_wen) begin
            r_drive <= 1'b0;
        end else begin
            r_drive <= 1'b1;
            r_rdata <= w_valid ? r_mem[w_index] : 32'h0;
        end
    end

    // Sticky error flags and saturating activity counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_misaligned <= 1'b0;
            r_err_range      <= 1'b0;
            r_rd_count       <= 16'h0;
            r_wr_count       <= 16'h0;
        end else begin
            if (!w_aligned) begin
                r_err_misaligned <= 1'b1;
            end
            if (w_aligned && !w_in_range) begin
                r_err_range <= 1'b1;
            end
            if (bus.dmem_wen) begin
                if (w_valid && (r_wr_count != 16'hFFFF)) begin
                    r_wr_count <= r_wr_count + 16'h1;
                end
            end else if (r_rd_count != 16'hFFFF) begin
                r_rd_count <= r_rd_count + 16'h1;
            end
        end
    end

    // Drive only while a read result is held and the CPU is not writing.
    assign dmem_data = (r_drive && !bus.dmem_wen) ? r_rdata : 32'hz;

    assign bus.err_misaligned = r_err_misaligned;
    assign bus.err_range      = r_err_range;
    assign bus.rd_count       = r_rd_count;
    assign bus.wr_count       = r_wr_count;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words of storage (power of two, 16..4096).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port dmem_addr, input, 32 bits: byte address from the CPU.
REQ-005 The block SHALL have port dmem_data, inout, 32 bits: bidirectional data bus (CPU drives on write, block drives on read).
REQ-006 The block SHALL have port dmem_wen, input, 1 bit: 1 = write cycle, 0 = read cycle.
REQ-007 The block SHALL have port err_misaligned, output, 1 bit: sticky flag set on access with dmem_addr[1:0] != 0.
REQ-008 The block SHALL have port err_range, output, 1 bit: sticky flag set on aligned access with word index >= DEPTH_WORDS.
REQ-009 The block SHALL have port rd_count, output, 16 bits: number of read cycles accepted, saturating.
REQ-010 The block SHALL have port wr_count, output, 16 bits: number of valid writes committed, saturating.

Function
REQ-011 Word index SHALL be dmem_addr[31:2]; an access SHALL be valid only when dmem_addr[1:0] == 0 and index < DEPTH_WORDS.
REQ-012 Write: on a rising edge with dmem_wen=1 and a valid access, mem[index] SHALL take the dmem_data value; invalid writes SHALL leave memory unchanged.
REQ-013 Read: on a rising edge with dmem_wen=0, rdata_q SHALL capture mem[index] for a valid access, else 32'h0; drive_q SHALL be set to 1.
REQ-014 On a rising edge with dmem_wen=1, drive_q SHALL be cleared to 0 (read latency: data appears the cycle after the address).
REQ-015 dmem_data SHALL be driven with rdata_q exactly when drive_q=1 and dmem_wen=0, and be high-Z otherwise (combinational release on dmem_wen rising: no bus contention).
REQ-016 Write followed by a read of the same address on the next edge SHALL return the newly written data.
REQ-017 err_misaligned SHALL set on any edge (read or write) with dmem_addr[1:0] != 0 and remain set until reset.
REQ-018 err_range SHALL set on any edge with aligned dmem_addr and index >= DEPTH_WORDS and remain set until reset; both flags MAY set independently.
REQ-019 rd_count SHALL increment by 1 on every edge with dmem_wen=0 (valid or not) and hold at 16'hFFFF.
REQ-020 wr_count SHALL increment by 1 only on committed valid writes and hold at 16'hFFFF.
REQ-021 An unknown (X) dmem_wen SHALL be treated as a read for counting and SHALL NOT modify memory.

Reset
REQ-022 While rst_n=0: drive_q=0, rdata_q=0, err_misaligned=0, err_range=0, rd_count=0, wr_count=0, dmem_data high-Z, independent of clk.
REQ-023 Memory contents SHALL NOT be altered by reset; power-up contents SHALL be all zero.
REQ-024 Reset asserted mid-read SHALL release dmem_data within the same simulation time step; first read after deassertion SHALL follow REQ-013 with no extra latency.

Verification
REQ-025 Write 32'hCAFE_F00D to 0x10, then read 0x10 -> next cycle dmem_data = 32'hCAFE_F00D; wr_count=1, rd_count=1.
REQ-026 Read 0x04 at power-up -> dmem_data = 0 one cycle later; dmem_data high-Z on any cycle with dmem_wen=1.
REQ-027 Write to 0x13 (misaligned) then read 0x10 -> err_misaligned=1, wr_count unchanged, mem[4] unchanged.
REQ-028 With DEPTH_WORDS=256, read 0x400 -> err_range=1, dmem_data = 0 next cycle; err_misaligned stays 0.
REQ-029 Drive 65540 read cycles -> rd_count saturates at 16'hFFFF; pulse rst_n low mid-read -> counters/flags 0, dmem_data high-Z immediately, prior mem data still readable after reset.
